// File: rtl/led_scan_controller.sv
// Column scan sequencer for the NxN LED array driver.
// Steps x through 0..N-1, each column preceded by a blanking guard and held for
// a programmable dwell. The displayed grid is double-buffered and only swapped
// at a frame boundary (or while idle) so a new generation never tears.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | scan stopped, ena=0, x=0; a full pending buffer is swapped in
// S_BLANK | ena=0 guard interval before the current column is driven
// S_DRIVE | ena=1, column x lit for DWELL_CYCLES clocks
module led_scan_controller #(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N*N-1:0]     cells_in,
    input  logic               update_valid,
    output logic               update_ready,
    output logic               ena,
    output logic [$clog2(N):0] x,
    output logic [N*N-1:0]     cells,
    output logic               frame_done
);

    localparam int XW   = $clog2(N) + 1;
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DWELL_LOAD = (DWELL_CYCLES > 0) ? CW'(DWELL_CYCLES - 1) : '0;
    localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [XW-1:0] LAST_X     = XW'(N - 1);

    generate
        if (N < 1 || N > 8) begin : g_bad_n
            $error("led_scan_controller: N must be in 1..8");
        end
        if (DWELL_CYCLES < 1) begin : g_bad_dwell
            $error("led_scan_controller: DWELL_CYCLES must be >= 1");
        end
        if (BLANK_CYCLES < 0) begin : g_bad_blank
            $error("led_scan_controller: BLANK_CYCLES must be >= 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ena_d;
    logic [XW-1:0]   x_d;
    logic            frame_done_d;
    logic            wrap;

    logic [N*N-1:0]  pending;
    logic            accept;
    logic            swap;

    // Scan state register; outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ena        <= 1'b0;
            x          <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ena        <= ena_d;
            x          <= x_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state, dwell/blank timing and next output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ena_d        = ena;
        x_d          = x;
        frame_done_d = 1'b0;
        wrap         = 1'b0;
        case (state_q)
            S_IDLE: begin
                ena_d = 1'b0;
                x_d   = '0;
                if (enable) begin
                    if (BLANK_CYCLES == 0) begin
                        state_d = S_DRIVE;
                        cnt_d   = DWELL_LOAD;
                        ena_d   = 1'b1;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LOAD;
                    end
                end
            end
            S_BLANK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    ena_d   = 1'b0;
                    x_d     = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_DRIVE;
                    cnt_d   = DWELL_LOAD;
                    ena_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRIVE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    ena_d   = 1'b0;
                    x_d     = '0;
                end else if (cnt_q == '0) begin
                    wrap         = (x == LAST_X);
                    x_d          = wrap ? '0 : x + XW'(1);
                    frame_done_d = wrap;
                    if (BLANK_CYCLES == 0) begin
                        cnt_d = DWELL_LOAD;
                        ena_d = 1'b1;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LOAD;
                        ena_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                ena_d   = 1'b0;
                x_d     = '0;
            end
        endcase
    end

    // Accept and swap are mutually exclusive: accept needs an empty buffer, swap a full one
    assign accept = update_valid && update_ready;
    assign swap   = !update_ready && (wrap || state_q == S_IDLE);

    // Double buffer: pending holds the next generation until a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            cells        <= '0;
            update_ready <= 1'b1;
        end else if (swap) begin
            cells        <= pending;
            update_ready <= 1'b1;
        end else if (accept) begin
            pending      <= cells_in;
            update_ready <= 1'b0;
        end
    end

endmodule
